mfp_ahb_draw_gpio: RTL and testbench
====================================

Name: mfp_ahb_draw_gpio

Overview:
AHB-Lite GPIO slave for the MIPSfpga system bus. It generalises LED/switch/pushbutton I/O and line-drawing control to NUM_CH independent drawing-engine channels with parametrised coordinate width. Per channel it provides shadowed coordinates, a single-cycle start pulse, busy tracking, sticky done/error flags and a combined interrupt. It sits on the AHB decoder beside RAM/ROM and drives the line-drawing engines directly.

Parameters:
- NUM_CH, 2, number of drawing channels (1..6).
- COORD_W, 13, coordinate width in bits (1..16).
- N_SW, 16, switch count.
- N_PB, 5, pushbutton count (≤16).
- N_LED, 16, LED count.
- ADDR_W, 8, HADDR width; must cover 0x20*(NUM_CH+1).

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  ADDR_W  byte address, address phase.
- HTRANS  in  2  transfer type.
- HWDATA  in  32  write data, data phase.
- HWRITE  in  1  write/read.
- HSEL  in  1  slave select.
- HRDATA  out  32  registered read data.
- IO_Switch  in  N_SW  asynchronous switches.
- IO_PB  in  N_PB  asynchronous pushbuttons.
- IO_LED  out  N_LED  LED register.
- IRQ  out  1  registered interrupt.
- DRAW_X0/DRAW_Y0/DRAW_X1/DRAW_Y1  out  NUM_CH*COORD_W each  active coordinates; channel c occupies [c*COORD_W +: COORD_W].
- DRAW_START  out  NUM_CH  one-cycle start pulse.
- DRAW_RESET  out  NUM_CH  engine soft reset, level.
- DRAW_FINISH  in  NUM_CH  engine done level, HCLK domain.

Behaviour:
- Clocking and reset:
  - One clock, HCLK. Reset is asynchronous and active-low on HRESETn.
  - Every register, and therefore every output, resets to 0.
- Write path:
  - Address-phase HADDR, HWRITE, HSEL and HTRANS are registered.
  - we = HSEL_d & HWRITE_d & (HTRANS_d != IDLE).
  - Registers update at the end of the data phase. Zero wait states.
- Read path:
  - HRDATA is registered from the address-phase HADDR decode every cycle.
  - Unmapped addresses and unused bits read 0. Sub-word writes are treated as full-word.
- Common map:
  - 0x00 LED: RW.
  - 0x04 SW: RO, 2-flop synchronised.
  - 0x08 PB: RO, 2-flop synchronised.
  - 0x0C PB_EDGE: sticky rising edge of synchronised PB, W1C.
  - 0x10 IRQ_EN: bits[NUM_CH-1:0] enable done; bit16 enables PB_EDGE.
  - 0x14 DONE: W1C.
  - 0x18 BUSY: RO.
  - 0x1C ERR: W1C.
- Channel map, base B = 0x20*(c+1):
  - B+0 X0, B+4 Y0, B+8 X1, B+C Y1: shadow coordinates, RW, COORD_W bits.
  - B+10 CTRL: bit0 START (write-1, reads 0); bit1 SRST (RW level, drives DRAW_RESET[c]).
- Start:
  - Writing CTRL with bit0=1 while the channel is not busy and SRST=0 does all of the following in the same edge:
    - copies the shadow coordinates to the DRAW_* outputs;
    - pulses DRAW_START[c] high for exactly the next cycle;
    - sets BUSY[c].
  - Shadow registers may be rewritten while busy; the DRAW_* outputs stay stable until the next accepted start.
- Finish:
  - fin_rise = DRAW_FINISH & ~fin_q. fin_q resets to 0.
  - fin_rise while busy clears BUSY[c] and sets DONE[c].
  - fin_rise while not busy is ignored.
- Start rejection:
  - A start while busy is dropped and sets ERR[c].
  - A start while SRST=1 is dropped silently.
- SRST=1:
  - Forces BUSY[c]=0.
  - fin_rise is ignored.
- Priorities:
  - fin_rise and a start in the same cycle: the finish is processed first and the start is accepted. Result: DONE set, BUSY stays 1, pulse issued.
  - Hardware set beats a W1C clear in the same cycle, for DONE, ERR and PB_EDGE.
- Read/write hazard: a read in the cycle immediately after a write to the same address returns the post-write value. This is handled by a forward/merge from the registered write path.
- IRQ: registered, IRQ <= |(DONE & IRQ_EN[NUM_CH-1:0]) | (IRQ_EN[16] & |PB_EDGE). It has one cycle of latency after the flag sets.
- SW/PB: reads see the pin value 2 cycles late. A PB_EDGE flag appears 3 cycles after the pin rises.

Decomposition:
- Shared include mfp_ahb_const.vh gains:
  - register offsets H_DRAW_LED_OFF … H_DRAW_ERR_OFF;
  - channel stride H_DRAW_CH_STRIDE = 0x20;
  - channel field offsets X0/Y0/X1/Y1/CTRL;
  - CTRL bit indices.
- Sub-module mfp_draw_chan_regs, one instance per channel via generate. It contains:
  - shadow and active coordinates;
  - start/busy/finish-edge logic;
  - SRST.
  - Outputs: busy, done_set, err_set, read data.
- The top level holds the AHB decode, common registers, W1C flag registers, synchronisers, IRQ and the HRDATA mux.

Test Plan:
1. Reset, then read every register: all read 0. IO_LED=0, DRAW_START=0, IRQ=0.
2. Ch0 programming:
   - Stimulus: write X0=5, Y0=7, X1=100, Y1=200, then CTRL=1.
   - DRAW_START[0] is high exactly 1 cycle.
   - DRAW_X1[12:0]=100.
   - BUSY=0x1.
   - Rewrite shadow X1=9 afterwards: DRAW_X1 stays 100.
3. Finish and clear:
   - Stimulus: IRQ_EN=0x1, raise DRAW_FINISH[0].
   - DONE=0x1, BUSY=0, IRQ=1 one cycle after DONE.
   - Write DONE=0x1: DONE=0, IRQ=0.
4. Start while busy:
   - Stimulus: second CTRL=1 on ch1 while busy.
   - No pulse, ERR=0x2.
   - DRAW_FINISH rising in the same cycle as a CTRL=1 write: DONE set and a new pulse is issued.
5. Soft reset and W1C race:
   - CTRL=2 during busy: BUSY clears, DRAW_RESET[c]=1, a later finish edge does not set DONE.
   - W1C of DONE in the same cycle as fin_rise: DONE remains 1.
6. Pushbutton and LED:
   - IO_PB[2] rises: PB read=0x4 after 2 cycles, PB_EDGE=0x4 and, with IRQ_EN bit16 set, IRQ=1.
   - LED write 0xA5A5 followed by an immediate read of 0x00 returns 0xA5A5.
   - HRESETn asserted mid-draw clears all outputs asynchronously.

Source files
------------

// File: rtl/mfp_ahb_draw_gpio_pkg.sv
// Shared constants for the AHB GPIO / line-draw control slave.
// Register offsets, channel field offsets, CTRL/IRQ_EN bit positions.
// Pure declarations; no timing or flow control of its own.
package mfp_ahb_draw_gpio_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Common register block, byte offsets within the first 0x20 window
  localparam logic [4:0] H_DRAW_LED_OFF     = 5'h00;
  localparam logic [4:0] H_DRAW_SW_OFF      = 5'h04;
  localparam logic [4:0] H_DRAW_PB_OFF      = 5'h08;
  localparam logic [4:0] H_DRAW_PB_EDGE_OFF = 5'h0C;
  localparam logic [4:0] H_DRAW_IRQ_EN_OFF  = 5'h10;
  localparam logic [4:0] H_DRAW_DONE_OFF    = 5'h14;
  localparam logic [4:0] H_DRAW_BUSY_OFF    = 5'h18;
  localparam logic [4:0] H_DRAW_ERR_OFF     = 5'h1C;

  // Channel c lives at H_DRAW_CH_STRIDE*(c+1)
  localparam int H_DRAW_CH_STRIDE = 32'h20;

  localparam logic [4:0] H_DRAW_X0_OFF   = 5'h00;
  localparam logic [4:0] H_DRAW_Y0_OFF   = 5'h04;
  localparam logic [4:0] H_DRAW_X1_OFF   = 5'h08;
  localparam logic [4:0] H_DRAW_Y1_OFF   = 5'h0C;
  localparam logic [4:0] H_DRAW_CTRL_OFF = 5'h10;

  localparam int H_DRAW_CTRL_START_BIT = 0;
  localparam int H_DRAW_CTRL_SRST_BIT  = 1;
  localparam int H_DRAW_IRQ_EN_PB_BIT  = 16;

  // Word match inside a 0x20 window; byte lanes are ignored so sub-word
  // accesses behave as full-word ones.
  function automatic logic is_off(input logic [4:0] addr, input logic [4:0] off);
    return addr[4:2] == off[4:2];
  endfunction

endpackage

// File: rtl/mfp_draw_chan_regs.sv
// One drawing channel: shadow/active coordinates, start pulse, busy, SRST.
// Start pulse one cycle after the accepting write; done/err set strobes combinational.
// No backpressure: starts while busy are dropped and flagged as errors.
module mfp_draw_chan_regs
  import mfp_ahb_draw_gpio_pkg::*;
#(
  parameter int COORD_W = 13
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_we,
  input  logic [4:0]         i_waddr,
  input  logic [31:0]        i_wdata,
  input  logic [4:0]         i_raddr,
  input  logic               i_fwd,
  input  logic               i_finish,
  output logic [COORD_W-1:0] o_x0,
  output logic [COORD_W-1:0] o_y0,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_y1,
  output logic               o_start,
  output logic               o_srst,
  output logic               o_busy,
  output logic               o_done_set,
  output logic               o_err_set,
  output logic [31:0]        o_rdata
);

  logic [COORD_W-1:0] r_sx0, r_sy0, r_sx1, r_sy1;
  logic [COORD_W-1:0] r_ax0, r_ay0, r_ax1, r_ay1;
  logic [COORD_W-1:0] w_sx0_nxt, w_sy0_nxt, w_sx1_nxt, w_sy1_nxt;
  logic               r_srst, r_busy, r_start, r_fin_q;
  logic               w_srst_nxt, w_busy_nxt, w_wr_ctrl;
  logic               w_fin_rise, w_fin_ok, w_idle, w_start_req, w_accept;
  logic               w_unused;

  assign w_unused = ^i_wdata;

  // Register-file next state from the bus write
  always_comb begin
    w_sx0_nxt  = r_sx0;
    w_sy0_nxt  = r_sy0;
    w_sx1_nxt  = r_sx1;
    w_sy1_nxt  = r_sy1;
    w_srst_nxt = r_srst;
    w_wr_ctrl  = 1'b0;
    if (i_we) begin
      if (is_off(i_waddr, H_DRAW_X0_OFF)) w_sx0_nxt = i_wdata[COORD_W-1:0];
      if (is_off(i_waddr, H_DRAW_Y0_OFF)) w_sy0_nxt = i_wdata[COORD_W-1:0];
      if (is_off(i_waddr, H_DRAW_X1_OFF)) w_sx1_nxt = i_wdata[COORD_W-1:0];
      if (is_off(i_waddr, H_DRAW_Y1_OFF)) w_sy1_nxt = i_wdata[COORD_W-1:0];
      if (is_off(i_waddr, H_DRAW_CTRL_OFF)) begin
        w_wr_ctrl  = 1'b1;
        w_srst_nxt = i_wdata[H_DRAW_CTRL_SRST_BIT];
      end
    end
  end

  // A finish edge is only meaningful while a draw is outstanding and the
  // engine is out of soft reset; it frees the channel for a same-cycle start.
  assign w_fin_rise  = i_finish & ~r_fin_q;
  assign w_fin_ok    = w_fin_rise & r_busy & ~r_srst;
  assign w_idle      = ~r_busy | w_fin_ok;
  assign w_start_req = w_wr_ctrl & i_wdata[H_DRAW_CTRL_START_BIT];
  assign w_accept    = w_start_req & ~r_srst & ~w_srst_nxt & w_idle;
  assign o_err_set   = w_start_req & ~r_srst & ~w_idle;
  assign o_done_set  = w_fin_ok;

  // Busy tracking: soft reset dominates, then start, then finish
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_srst_nxt)    w_busy_nxt = 1'b0;
    else if (w_accept) w_busy_nxt = 1'b1;
    else if (w_fin_ok) w_busy_nxt = 1'b0;
  end

  // Channel state registers; active coords latch only on an accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sx0 <= '0; r_sy0 <= '0; r_sx1 <= '0; r_sy1 <= '0;
      r_ax0 <= '0; r_ay0 <= '0; r_ax1 <= '0; r_ay1 <= '0;
      r_srst  <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_fin_q <= 1'b0;
    end else begin
      r_sx0   <= w_sx0_nxt;
      r_sy0   <= w_sy0_nxt;
      r_sx1   <= w_sx1_nxt;
      r_sy1   <= w_sy1_nxt;
      r_srst  <= w_srst_nxt;
      r_busy  <= w_busy_nxt;
      r_start <= w_accept;
      r_fin_q <= i_finish;
      if (w_accept) begin
        r_ax0 <= r_sx0;
        r_ay0 <= r_sy0;
        r_ax1 <= r_sx1;
        r_ay1 <= r_sy1;
      end
    end
  end

  // Read view; i_fwd selects post-write values for a read right after a write
  always_comb begin
    o_rdata = '0;
    if (is_off(i_raddr, H_DRAW_X0_OFF)) o_rdata = 32'(i_fwd ? w_sx0_nxt : r_sx0);
    if (is_off(i_raddr, H_DRAW_Y0_OFF)) o_rdata = 32'(i_fwd ? w_sy0_nxt : r_sy0);
    if (is_off(i_raddr, H_DRAW_X1_OFF)) o_rdata = 32'(i_fwd ? w_sx1_nxt : r_sx1);
    if (is_off(i_raddr, H_DRAW_Y1_OFF)) o_rdata = 32'(i_fwd ? w_sy1_nxt : r_sy1);
    if (is_off(i_raddr, H_DRAW_CTRL_OFF))
      o_rdata[H_DRAW_CTRL_SRST_BIT] = i_fwd ? w_srst_nxt : r_srst;
  end

  assign o_x0    = r_ax0;
  assign o_y0    = r_ay0;
  assign o_x1    = r_ax1;
  assign o_y1    = r_ay1;
  assign o_start = r_start;
  assign o_srst  = r_srst;
  assign o_busy  = r_busy;

endmodule

// File: rtl/mfp_ahb_draw_gpio.sv
// AHB-Lite GPIO slave: LEDs, switches, pushbuttons and NUM_CH line-draw channels.
// Zero wait states; HRDATA registered one cycle after the address phase.
// Never stalls the bus (no HREADY); draw engines have no backpressure path.
module mfp_ahb_draw_gpio
  import mfp_ahb_draw_gpio_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int COORD_W = 13,
  parameter int N_SW    = 16,
  parameter int N_PB    = 5,
  parameter int N_LED   = 16,
  parameter int ADDR_W  = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [31:0]               HWDATA,
  input  logic                      HWRITE,
  input  logic                      HSEL,
  output logic [31:0]               HRDATA,
  input  logic [N_SW-1:0]           IO_Switch,
  input  logic [N_PB-1:0]           IO_PB,
  output logic [N_LED-1:0]          IO_LED,
  output logic                      IRQ,
  output logic [NUM_CH*COORD_W-1:0] DRAW_X0,
  output logic [NUM_CH*COORD_W-1:0] DRAW_Y0,
  output logic [NUM_CH*COORD_W-1:0] DRAW_X1,
  output logic [NUM_CH*COORD_W-1:0] DRAW_Y1,
  output logic [NUM_CH-1:0]         DRAW_START,
  output logic [NUM_CH-1:0]         DRAW_RESET,
  input  logic [NUM_CH-1:0]         DRAW_FINISH
);

  localparam int RG_W = ADDR_W - 5;

  logic [ADDR_W-1:0] r_haddr_d;
  logic [1:0]        r_htrans_d;
  logic              r_hwrite_d, r_hsel_d;
  logic [31:0]       r_hrdata, w_rdata;
  logic [N_LED-1:0]  r_led, w_led_nxt;
  logic [N_SW-1:0]   r_sw_s1, r_sw_s2;
  logic [N_PB-1:0]   r_pb_s1, r_pb_s2, r_pb_q, r_pb_edge, w_pb_edge_nxt, w_pb_rise;
  logic [NUM_CH-1:0] r_irq_en_ch, w_irq_en_ch_nxt;
  logic              r_irq_en_pb, w_irq_en_pb_nxt, r_irq;
  logic [NUM_CH-1:0] r_done, r_err, w_done_nxt, w_err_nxt;
  logic [NUM_CH-1:0] w_busy, w_done_set, w_err_set;
  logic [31:0]       w_ch_rdata [NUM_CH];
  logic              w_we, w_wcom, w_fwd;
  logic [RG_W-1:0]   w_wreg, w_rreg;
  logic [4:0]        w_woff;

  assign w_we   = r_hsel_d & r_hwrite_d & (r_htrans_d != HTRANS_IDLE);
  assign w_wreg = r_haddr_d[ADDR_W-1:5];
  assign w_rreg = HADDR[ADDR_W-1:5];
  assign w_woff = r_haddr_d[4:0];
  assign w_wcom = w_we & (w_wreg == '0);
  assign w_fwd  = w_we & (r_haddr_d[ADDR_W-1:2] == HADDR[ADDR_W-1:2]);

  // Common registers: plain RW, and W1C flags where a hardware set wins
  always_comb begin
    w_led_nxt       = r_led;
    w_irq_en_ch_nxt = r_irq_en_ch;
    w_irq_en_pb_nxt = r_irq_en_pb;
    w_pb_rise       = r_pb_s2 & ~r_pb_q;
    w_pb_edge_nxt   = r_pb_edge;
    w_done_nxt      = r_done;
    w_err_nxt       = r_err;
    if (w_wcom) begin
      if (is_off(w_woff, H_DRAW_LED_OFF))     w_led_nxt     = HWDATA[N_LED-1:0];
      if (is_off(w_woff, H_DRAW_PB_EDGE_OFF)) w_pb_edge_nxt = r_pb_edge & ~HWDATA[N_PB-1:0];
      if (is_off(w_woff, H_DRAW_DONE_OFF))    w_done_nxt    = r_done & ~HWDATA[NUM_CH-1:0];
      if (is_off(w_woff, H_DRAW_ERR_OFF))     w_err_nxt     = r_err & ~HWDATA[NUM_CH-1:0];
      if (is_off(w_woff, H_DRAW_IRQ_EN_OFF)) begin
        w_irq_en_ch_nxt = HWDATA[NUM_CH-1:0];
        w_irq_en_pb_nxt = HWDATA[H_DRAW_IRQ_EN_PB_BIT];
      end
    end
    w_pb_edge_nxt = w_pb_edge_nxt | w_pb_rise;
    w_done_nxt    = w_done_nxt | w_done_set;
    w_err_nxt     = w_err_nxt | w_err_set;
  end

  // Bus pipeline, synchronisers, common registers, IRQ and read data
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr_d   <= '0;
      r_htrans_d  <= '0;
      r_hwrite_d  <= 1'b0;
      r_hsel_d    <= 1'b0;
      r_hrdata    <= '0;
      r_led       <= '0;
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_pb_s1     <= '0;
      r_pb_s2     <= '0;
      r_pb_q      <= '0;
      r_pb_edge   <= '0;
      r_irq_en_ch <= '0;
      r_irq_en_pb <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_haddr_d   <= HADDR;
      r_htrans_d  <= HTRANS;
      r_hwrite_d  <= HWRITE;
      r_hsel_d    <= HSEL;
      r_hrdata    <= w_rdata;
      r_led       <= w_led_nxt;
      r_sw_s1     <= IO_Switch;
      r_sw_s2     <= r_sw_s1;
      r_pb_s1     <= IO_PB;
      r_pb_s2     <= r_pb_s1;
      r_pb_q      <= r_pb_s2;
      r_pb_edge   <= w_pb_edge_nxt;
      r_irq_en_ch <= w_irq_en_ch_nxt;
      r_irq_en_pb <= w_irq_en_pb_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_irq       <= (|(r_done & r_irq_en_ch)) | (r_irq_en_pb & (|r_pb_edge));
    end
  end

  // Read mux from the address-phase HADDR, with post-write forwarding
  always_comb begin
    w_rdata = '0;
    if (w_rreg == '0) begin
      case ({HADDR[4:2], 2'b00})
        H_DRAW_LED_OFF:     w_rdata = 32'(w_fwd ? w_led_nxt : r_led);
        H_DRAW_SW_OFF:      w_rdata = 32'(r_sw_s2);
        H_DRAW_PB_OFF:      w_rdata = 32'(r_pb_s2);
        H_DRAW_PB_EDGE_OFF: w_rdata = 32'(w_fwd ? w_pb_edge_nxt : r_pb_edge);
        H_DRAW_IRQ_EN_OFF: begin
          w_rdata = 32'(w_fwd ? w_irq_en_ch_nxt : r_irq_en_ch);
          w_rdata[H_DRAW_IRQ_EN_PB_BIT] = w_fwd ? w_irq_en_pb_nxt : r_irq_en_pb;
        end
        H_DRAW_DONE_OFF:    w_rdata = 32'(w_fwd ? w_done_nxt : r_done);
        H_DRAW_BUSY_OFF:    w_rdata = 32'(w_busy);
        H_DRAW_ERR_OFF:     w_rdata = 32'(w_fwd ? w_err_nxt : r_err);
        default:            w_rdata = '0;
      endcase
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_rreg == RG_W'(c + 1)) w_rdata = w_ch_rdata[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mfp_draw_chan_regs #(.COORD_W(COORD_W)) u_chan (
      .i_clk      (HCLK),
      .i_rst_n    (HRESETn),
      .i_we       (w_we & (w_wreg == RG_W'(c + 1))),
      .i_waddr    (w_woff),
      .i_wdata    (HWDATA),
      .i_raddr    (HADDR[4:0]),
      .i_fwd      (w_fwd),
      .i_finish   (DRAW_FINISH[c]),
      .o_x0       (DRAW_X0[c*COORD_W +: COORD_W]),
      .o_y0       (DRAW_Y0[c*COORD_W +: COORD_W]),
      .o_x1       (DRAW_X1[c*COORD_W +: COORD_W]),
      .o_y1       (DRAW_Y1[c*COORD_W +: COORD_W]),
      .o_start    (DRAW_START[c]),
      .o_srst     (DRAW_RESET[c]),
      .o_busy     (w_busy[c]),
      .o_done_set (w_done_set[c]),
      .o_err_set  (w_err_set[c]),
      .o_rdata    (w_ch_rdata[c])
    );
  end

  assign HRDATA = r_hrdata;
  assign IO_LED = r_led;
  assign IRQ    = r_irq;

endmodule

// File: tb/tb_mfp_ahb_draw_gpio.sv
// Scoreboard bench for mfp_ahb_draw_gpio: reads and pin probes queue expectations,
// a negedge monitor pops and compares them.
// Directed vectors with hand-computed results.
module tb_mfp_ahb_draw_gpio;
  localparam int NUM_CH = 2, COORD_W = 13, N_SW = 16, N_PB = 5, N_LED = 16, ADDR_W = 8;
  localparam int P_START = 0, P_X1 = 1, P_IRQ = 2, P_LED = 3, P_RST = 4;

  logic                      HCLK = 1'b0;
  logic                      HRESETn = 1'b0;
  logic [ADDR_W-1:0]         HADDR = '0;
  logic [1:0]                HTRANS = '0;
  logic [31:0]               HWDATA = '0;
  logic                      HWRITE = 1'b0;
  logic                      HSEL = 1'b0;
  logic [31:0]               HRDATA;
  logic [N_SW-1:0]           IO_Switch = '0;
  logic [N_PB-1:0]           IO_PB = '0;
  logic [N_LED-1:0]          IO_LED;
  logic                      IRQ;
  logic [NUM_CH*COORD_W-1:0] DRAW_X0, DRAW_Y0, DRAW_X1, DRAW_Y1;
  logic [NUM_CH-1:0]         DRAW_START, DRAW_RESET;
  logic [NUM_CH-1:0]         DRAW_FINISH = '0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_draw_gpio #(
    .NUM_CH(NUM_CH), .COORD_W(COORD_W), .N_SW(N_SW),
    .N_PB(N_PB), .N_LED(N_LED), .ADDR_W(ADDR_W)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA),
    .IO_Switch(IO_Switch), .IO_PB(IO_PB), .IO_LED(IO_LED), .IRQ(IRQ),
    .DRAW_X0(DRAW_X0), .DRAW_Y0(DRAW_Y0), .DRAW_X1(DRAW_X1), .DRAW_Y1(DRAW_Y1),
    .DRAW_START(DRAW_START), .DRAW_RESET(DRAW_RESET), .DRAW_FINISH(DRAW_FINISH)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  int          pin_sel_q[$];
  logic [31:0] pin_exp_q[$];
  string       pin_name_q[$];
  logic        rd_issue = 1'b0;
  logic        rd_dphase = 1'b0;

  always @(posedge HCLK) rd_dphase <= rd_issue;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      P_START: return 32'(DRAW_START);
      P_X1:    return 32'(DRAW_X1[COORD_W-1:0]);
      P_IRQ:   return 32'(IRQ);
      P_LED:   return 32'(IO_LED);
      P_RST:   return 32'(DRAW_RESET);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare read data in each read data phase, then pending pin probes
  initial begin
    logic [31:0] e;
    logic [31:0] got;
    string       n;
    int          s;
    forever begin
      @(negedge HCLK);
      if (rd_dphase) begin
        total++;
        if (rd_exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: got %08h required nothing queued", HRDATA);
        end else begin
          e = rd_exp_q.pop_front();
          n = rd_name_q.pop_front();
          if (HRDATA !== e) begin
            bad++;
            $display("FAIL %s: HRDATA got %08h required %08h", n, HRDATA, e);
          end
        end
      end
      while (pin_sel_q.size() > 0) begin
        s = pin_sel_q.pop_front();
        e = pin_exp_q.pop_front();
        n = pin_name_q.pop_front();
        got = probe(s);
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL %s: pin got %08h required %08h", n, got, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Address phase now; returns at the start of the data phase with HWDATA driven
  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    HADDR = a; HWRITE = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = d;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string n);
    HADDR = a; HWRITE = 1'b0; HSEL = 1'b1; HTRANS = 2'b10; rd_issue = 1'b1;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(n);
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00; rd_issue = 1'b0;
  endtask

  task automatic pin(input int s, input logic [31:0] e, input string n);
    pin_sel_q.push_back(s);
    pin_exp_q.push_back(e);
    pin_name_q.push_back(n);
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // 1. reset state
    tick(); tick();
    pin(P_LED, 0, "rst_led"); pin(P_START, 0, "rst_start"); pin(P_IRQ, 0, "rst_irq");
    tick();
    HRESETn = 1'b1;
    tick();
    for (int a = 0; a < 32; a += 4) bus_read(ADDR_W'(a), 0, $sformatf("rst_rd_%02h", a));
    for (int c = 1; c <= NUM_CH; c++)
      for (int f = 0; f <= 16; f += 4)
        bus_read(ADDR_W'(c * 32 + f), 0, $sformatf("rst_rd_%02h", c * 32 + f));

    // 2. ch0 programming and start pulse
    bus_write(8'h20, 5); bus_write(8'h24, 7); bus_write(8'h28, 100); bus_write(8'h2C, 200);
    bus_write(8'h30, 1);
    tick();
    pin(P_START, 1, "start_pulse_hi"); pin(P_X1, 100, "draw_x1_latched");
    tick();
    pin(P_START, 0, "start_pulse_lo");
    bus_read(8'h18, 1, "busy_ch0");
    bus_write(8'h28, 9);
    tick();
    pin(P_X1, 100, "draw_x1_stable");
    bus_read(8'h28, 9, "shadow_x1_rewritten");

    // 3. finish, interrupt and W1C clear
    bus_write(8'h10, 1);
    tick();
    DRAW_FINISH = 2'b01;
    tick();
    pin(P_IRQ, 0, "irq_latency");
    tick();
    pin(P_IRQ, 1, "irq_done");
    bus_read(8'h14, 1, "done_ch0");
    bus_read(8'h18, 0, "busy_clear");
    DRAW_FINISH = 2'b00;
    bus_write(8'h14, 1);
    tick(); tick();
    pin(P_IRQ, 0, "irq_cleared");
    bus_read(8'h14, 0, "done_cleared");

    // 4. ch1 start while busy, then finish + start in one cycle
    bus_write(8'h50, 1);
    tick();
    pin(P_START, 2, "ch1_pulse_hi");
    tick();
    pin(P_START, 0, "ch1_pulse_lo");
    bus_write(8'h50, 1);
    tick();
    pin(P_START, 0, "busy_start_dropped");
    bus_read(8'h1C, 2, "err_ch1");
    bus_read(8'h18, 2, "busy_ch1");
    bus_write(8'h50, 1);
    DRAW_FINISH = 2'b10;
    tick();
    pin(P_START, 2, "fin_and_start_pulse");
    bus_read(8'h14, 2, "fin_and_start_done");
    bus_read(8'h18, 2, "fin_and_start_busy");
    DRAW_FINISH = 2'b00;

    // 5. soft reset during busy; W1C vs hardware set race
    bus_write(8'h50, 2);
    tick();
    pin(P_RST, 2, "draw_reset_ch1");
    bus_read(8'h18, 0, "srst_busy_clear");
    bus_read(8'h50, 2, "ctrl_readback");
    bus_write(8'h14, 2);
    tick();
    DRAW_FINISH = 2'b10;
    tick(); tick();
    bus_read(8'h14, 0, "srst_fin_ignored");
    DRAW_FINISH = 2'b00;
    bus_write(8'h30, 1);
    tick();
    bus_write(8'h14, 1);
    DRAW_FINISH = 2'b01;
    tick();
    bus_read(8'h14, 1, "w1c_race_done");
    DRAW_FINISH = 2'b00;

    // 6. pushbutton edge interrupt, LED hazard, async reset
    bus_write(8'h10, 32'h0001_0000);
    tick();
    bus_write(8'h14, 1);
    tick(); tick();
    pin(P_IRQ, 0, "irq_pb_idle");
    IO_PB = 5'b00100;
    bus_read(8'h08, 0, "pb_sync_0");
    bus_read(8'h08, 0, "pb_sync_1");
    bus_read(8'h08, 4, "pb_sync_2");
    pin(P_IRQ, 0, "irq_pb_latency");
    tick();
    pin(P_IRQ, 1, "irq_pb_edge");
    bus_read(8'h0C, 4, "pb_edge");
    bus_write(8'h00, 32'h0000_A5A5);
    bus_read(8'h00, 32'h0000_A5A5, "led_fwd");
    pin(P_LED, 32'h0000_A5A5, "led_pins");
    bus_write(8'h30, 1);
    tick();
    pin(P_START, 1, "mid_draw_pulse"); pin(P_X1, 9, "mid_draw_x1");
    @(negedge HCLK);
    #1;
    HRESETn = 1'b0;
    pin(P_START, 0, "arst_start"); pin(P_X1, 0, "arst_x1"); pin(P_LED, 0, "arst_led");
    pin(P_IRQ, 0, "arst_irq"); pin(P_RST, 0, "arst_draw_reset");
    tick(); tick();
    HRESETn = 1'b1;
    tick(); tick(); tick();

    total++;
    if (rd_exp_q.size() != 0 || pin_sel_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending reads %0d probes %0d required 0 0",
               rd_exp_q.size(), pin_sel_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
